// File: rtl/modexp_pkg.sv
// modexp_pkg: shared types and helpers for the modular-exponentiation engine.
//   state_t   : controller FSM states (IDLE, SQR, MUL, DONE)
//   idx_width : bit width of the exponent bit index, clog2(EXP_WIDTH), minimum 1
package modexp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SQR,
    MUL,
    DONE
  } state_t;

  function automatic int idx_width(input int unsigned w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/modexp_controller_multiplicator.sv
// multiplicator: combinational modular multiplier, product = a*b mod modulant.
// Built from two Montgomery reductions: mont(mont(a,b), R^2 mod n), where
// mont(x,y) = x*y*R^-1 mod n and R = 2^DATA_WIDTH.
// Ports:
//   a, b       in  operands, both < modulant
//   modulant   in  odd modulus > 1
//   R_div_two  in  R/2, the weight of the top operand bit
//   R_squared  in  R^2 mod modulant
//   product    out a*b mod modulant
module multiplicator #(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [DATA_WIDTH-1:0] modulant,
  input  logic [DATA_WIDTH-1:0] R_div_two,
  input  logic [DATA_WIDTH-1:0] R_squared,
  output logic [DATA_WIDTH-1:0] product
);

  // Two guard bits: the running sum stays below 4n.
  localparam int TW = DATA_WIDTH + 2;

  function automatic logic [DATA_WIDTH-1:0] mont(
    input logic [DATA_WIDTH-1:0] x,
    input logic [DATA_WIDTH-1:0] y,
    input logic [DATA_WIDTH-1:0] n,
    input logic [DATA_WIDTH-1:0] top
  );
    logic [TW-1:0] t;
    logic          xi;
    t = '0;
    for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
      // R/2 shifted down selects operand bit i, LSB first.
      xi = |(x & (top >> (DATA_WIDTH - 1 - i)));
      if (xi) t = t + {2'b00, y};
      if (t[0]) t = t + {2'b00, n};
      t = t >> 1;
    end
    if (t >= {2'b00, n}) t = t - {2'b00, n};
    return t[DATA_WIDTH-1:0];
  endfunction

  logic [DATA_WIDTH-1:0] mont_ab;

  always_comb begin
    mont_ab = mont(a, b, modulant, R_div_two);
    product = mont(mont_ab, R_squared, modulant, R_div_two);
  end

endmodule

// File: rtl/modexp_controller.sv
// modexp_controller: computes base^exponent mod modulant with left-to-right
// square-and-multiply, one multiplier step per clock.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   start           request, accepted only in IDLE
//   base, exponent, modulant, R_div_two, R_squared   operands, latched on accept
//   busy            high while squaring/multiplying
//   done            one-cycle pulse, result valid
//   result          final value, held until the next accepted start
// Build option: MODEXP_SKIP_LEADING_ZEROS_EN starts at the exponent's MSB with
// a direct MUL (skipping squarings of 1); exponent 0 completes immediately.
module modexp_controller #(
  parameter int DATA_WIDTH = 8,
  parameter int EXP_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] base,
  input  logic [EXP_WIDTH-1:0]  exponent,
  input  logic [DATA_WIDTH-1:0] modulant,
  input  logic [DATA_WIDTH-1:0] R_div_two,
  input  logic [DATA_WIDTH-1:0] R_squared,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result
);
  import modexp_pkg::*;

  localparam int IW = idx_width(EXP_WIDTH);
  localparam logic [DATA_WIDTH-1:0] ACC_ONE = DATA_WIDTH'(1);

  state_t                state_q, state_d;
  logic [IW-1:0]         idx_q;
  logic                  idx_dec;
  logic [DATA_WIDTH-1:0] acc_q, base_q, n_q, rd2_q, r2_q;
  logic [EXP_WIDTH-1:0]  exp_q;
  logic [DATA_WIDTH-1:0] mul_b, prod;

`ifdef MODEXP_SKIP_LEADING_ZEROS_EN
  function automatic logic [IW-1:0] msb_idx(input logic [EXP_WIDTH-1:0] e);
    msb_idx = '0;
    for (int unsigned i = 0; i < EXP_WIDTH; i++)
      if (e[i]) msb_idx = IW'(i);
  endfunction
`endif

  multiplicator #(.DATA_WIDTH(DATA_WIDTH)) u_mul (
    .a         (acc_q),
    .b         (mul_b),
    .modulant  (n_q),
    .R_div_two (rd2_q),
    .R_squared (r2_q),
    .product   (prod)
  );

  always_comb begin
    state_d = state_q;
    idx_dec = 1'b0;
    mul_b   = acc_q;
    busy    = (state_q == SQR) || (state_q == MUL);
    done    = (state_q == DONE);
    case (state_q)
      IDLE: begin
        if (start) begin
`ifdef MODEXP_SKIP_LEADING_ZEROS_EN
          state_d = (exponent == '0) ? DONE : MUL;
`else
          state_d = SQR;
`endif
        end
      end
      SQR: begin
        if (exp_q[idx_q]) begin
          state_d = MUL;
        end else if (idx_q == '0) begin
          state_d = DONE;
        end else begin
          idx_dec = 1'b1;
        end
      end
      MUL: begin
        mul_b = base_q;
        if (idx_q == '0) begin
          state_d = DONE;
        end else begin
          state_d = SQR;
          idx_dec = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      acc_q   <= ACC_ONE;
      base_q  <= '0;
      n_q     <= '0;
      rd2_q   <= '0;
      r2_q    <= '0;
      exp_q   <= '0;
      result  <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (start) begin
            base_q <= base;
            exp_q  <= exponent;
            n_q    <= modulant;
            rd2_q  <= R_div_two;
            r2_q   <= R_squared;
            acc_q  <= ACC_ONE;
`ifdef MODEXP_SKIP_LEADING_ZEROS_EN
            idx_q <= msb_idx(exponent);
            if (exponent == '0) result <= ACC_ONE;
`else
            idx_q <= IW'(EXP_WIDTH - 1);
`endif
          end
        end
        SQR, MUL: begin
          acc_q <= prod;
          if (idx_dec) idx_q <= idx_q - IW'(1);
          // Result is captured on the edge entering DONE so it is valid with done.
          if (state_d == DONE) result <= prod;
        end
        default: ;
      endcase
    end
  end

endmodule
